// File: rtl/cpu_sequencer_pkg.sv
// Shared codes for the CPU core: cpu_control state/opcode encodings and the
// run-control sequencer FSM encoding.
package cpu_sequencer_pkg;

    localparam int STATE_W = 4;

    // cpu_control state codes; the sequencer only reacts to NEXT and HALT.
    localparam logic [STATE_W-1:0] STATE_FETCH  = 4'h0;
    localparam logic [STATE_W-1:0] STATE_DECODE = 4'h1;
    localparam logic [STATE_W-1:0] STATE_EXEC   = 4'h2;
    localparam logic [STATE_W-1:0] STATE_MEM    = 4'h3;
    localparam logic [STATE_W-1:0] STATE_WB     = 4'h4;
    localparam logic [STATE_W-1:0] STATE_NEXT   = 4'hE;
    localparam logic [STATE_W-1:0] STATE_HALT   = 4'hF;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_RUN    = 3'd1,
        SEQ_STEP   = 3'd2,
        SEQ_PAUSED = 3'd3,
        SEQ_HALTED = 3'd4
    } seq_state_t;

    function automatic logic seq_active(seq_state_t s);
        return (s == SEQ_RUN) || (s == SEQ_STEP);
    endfunction

endpackage

// File: rtl/cpu_sequencer_cycle_counter.sv
// Micro-cycle counter for cpu_control: clears on instruction retire, counts on
// every other advance, and flags a sticky error when it runs past MAX_CYCLE.
module seq_cycle_counter #(
    parameter int CYCLE_W   = 4,
    parameter int MAX_CYCLE = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               advance,
    input  logic               clear,
    output logic [CYCLE_W-1:0] cycle,
    output logic               seq_err
);

    localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(MAX_CYCLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle   <= '0;
            seq_err <= 1'b0;
        end else if (clear) begin
            cycle <= '0;
        end else if (advance) begin
            if (cycle == LAST_CYCLE) begin
                // Overrun: the instruction never reported NEXT in time.
                cycle   <= '0;
                seq_err <= 1'b1;
            end else begin
                cycle <= cycle + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Run-control sequencer: run/pause/single-step, HLT stop, PC breakpoint and
// retired-instruction counter in front of cpu_control.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int CYCLE_W   = 4,
    parameter int PC_W      = 4,
    parameter int MAX_CYCLE = 7,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run_req,
    input  logic               pause_req,
    input  logic               step_req,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    pc,
    input  logic [STATE_W-1:0] state,
    output logic [CYCLE_W-1:0] cycle,
    output logic               cpu_en,
    output logic               halted,
    output logic               paused,
    output logic               bp_hit,
    output logic               seq_err,
    output logic [CNT_W-1:0]   instr_count
);

    seq_state_t fsm, fsm_next;
    logic       bp_skip, bp_skip_next;
    logic       pause_pend, pause_pend_next;
    logic       bp_hit_next;
    logic       bp_block;
    logic       is_next, is_halt;
    logic       retire, cnt_advance;

    assign is_next = (state == STATE_NEXT);
    assign is_halt = (state == STATE_HALT);

    // bp_skip lets a resume execute the instruction sitting on the breakpoint.
    assign bp_block = (fsm == SEQ_RUN) && (cycle == '0) && bp_en
                      && (pc == bp_addr) && !bp_skip;

    assign cpu_en      = seq_active(fsm) && !bp_block;
    assign retire      = cpu_en && is_next;
    assign cnt_advance = cpu_en && !is_next && !is_halt;

    assign halted = (fsm == SEQ_HALTED);
    assign paused = (fsm == SEQ_IDLE) || (fsm == SEQ_PAUSED);

    seq_cycle_counter #(
        .CYCLE_W   (CYCLE_W),
        .MAX_CYCLE (MAX_CYCLE)
    ) u_cycle (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (cnt_advance),
        .clear   (retire),
        .cycle   (cycle),
        .seq_err (seq_err)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm        <= SEQ_IDLE;
            bp_skip    <= 1'b0;
            pause_pend <= 1'b0;
            bp_hit     <= 1'b0;
        end else begin
            fsm        <= fsm_next;
            bp_skip    <= bp_skip_next;
            pause_pend <= pause_pend_next;
            bp_hit     <= bp_hit_next;
        end
    end

    // NOTE: every output of this block gets a default first so that no path
    // leaves a variable unassigned and infers a latch.
    always_comb begin
        fsm_next        = fsm;
        bp_skip_next    = bp_skip;
        pause_pend_next = pause_pend;
        bp_hit_next     = bp_hit;

        unique case (fsm)
            SEQ_IDLE, SEQ_PAUSED: begin
                if (run_req) begin
                    fsm_next     = SEQ_RUN;
                    bp_skip_next = 1'b1;
                    bp_hit_next  = 1'b0;
                end else if (step_req) begin
                    fsm_next     = SEQ_STEP;
                    bp_skip_next = 1'b1;
                    bp_hit_next  = 1'b0;
                end
            end

            SEQ_RUN: begin
                if (bp_block) begin
                    fsm_next        = SEQ_PAUSED;
                    bp_hit_next     = 1'b1;
                    pause_pend_next = 1'b0;
                end else if (is_next) begin
                    bp_skip_next = 1'b0;
                    if (pause_pend || pause_req) begin
                        fsm_next        = SEQ_PAUSED;
                        pause_pend_next = 1'b0;
                    end
                end else if (is_halt) begin
                    fsm_next        = SEQ_HALTED;
                    pause_pend_next = 1'b0;
                end else if (pause_req) begin
                    pause_pend_next = 1'b1;
                end
            end

            SEQ_STEP: begin
                if (is_next) begin
                    fsm_next     = SEQ_PAUSED;
                    bp_skip_next = 1'b0;
                end else if (is_halt) begin
                    fsm_next = SEQ_HALTED;
                end
            end

            default: begin
                fsm_next = fsm;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a behavioural model plays the rules
// cycle by cycle, the bench itself stands in for cpu_control and the PC.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam int MODE_IDLE = 0, MODE_RUN = 1, MODE_STEP = 2, MODE_PAUSED = 3, MODE_HALTED = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run_req = 1'b0, pause_req = 1'b0, step_req = 1'b0;
    logic        bp_en = 1'b0;
    logic [3:0]  bp_addr = 4'd0;
    logic [3:0]  pc;
    logic [3:0]  state;
    logic [3:0]  cycle;
    logic        cpu_en, halted, paused, bp_hit, seq_err;
    logic [15:0] instr_count;

    int next_at = 4;
    int halt_at = -1;
    int n_checks = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    cpu_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run_req     (run_req),
        .pause_req   (pause_req),
        .step_req    (step_req),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc          (pc),
        .state       (state),
        .cycle       (cycle),
        .cpu_en      (cpu_en),
        .halted      (halted),
        .paused      (paused),
        .bp_hit      (bp_hit),
        .seq_err     (seq_err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Stand-in for cpu_control: reports NEXT/HALT at chosen micro-cycles.
    always @* begin
        if (int'(cycle) == halt_at)      state = STATE_HALT;
        else if (int'(cycle) == next_at) state = STATE_NEXT;
        else                             state = STATE_EXEC;
    end

    // Stand-in datapath: PC moves on each retired instruction.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            pc <= 4'd0;
        else if (cpu_en && state == STATE_NEXT)  pc <= pc + 4'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode, m_cycle;
    logic [15:0] m_count;
    bit          m_hit, m_err, m_skip, m_pend;

    function automatic bit m_block();
        return m_mode == MODE_RUN && m_cycle == 0 && bp_en && pc == bp_addr && !m_skip;
    endfunction

    function automatic bit m_enable();
        return (m_mode == MODE_RUN || m_mode == MODE_STEP) && !m_block();
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = MODE_IDLE; m_cycle = 0; m_count = 16'd0;
            m_hit = 0; m_err = 0; m_skip = 0; m_pend = 0;
        end else if (m_mode == MODE_IDLE || m_mode == MODE_PAUSED) begin
            if (run_req || step_req) begin
                m_mode = run_req ? MODE_RUN : MODE_STEP;
                m_skip = 1; m_hit = 0;
            end
        end else if (m_mode == MODE_RUN && m_block()) begin
            m_mode = MODE_PAUSED; m_hit = 1; m_pend = 0;
        end else if (m_mode == MODE_RUN || m_mode == MODE_STEP) begin
            if (m_cycle == next_at && m_cycle != halt_at) begin
                m_count = m_count + 16'd1;
                m_cycle = 0;
                m_skip  = 0;
                if (m_mode == MODE_STEP || m_pend || pause_req) begin
                    m_mode = MODE_PAUSED; m_pend = 0;
                end
            end else if (m_cycle == halt_at) begin
                m_mode = MODE_HALTED; m_pend = 0;
            end else begin
                m_cycle = (m_cycle + 1) % 8;
                if (m_cycle == 0) m_err = 1;
                if (m_mode == MODE_RUN && pause_req) m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("cycle",       32'(cycle),       32'(m_cycle));
            check("cpu_en",      32'(cpu_en),      32'(m_enable()));
            check("halted",      32'(halted),      32'(m_mode == MODE_HALTED));
            check("paused",      32'(paused),      32'(m_mode == MODE_IDLE || m_mode == MODE_PAUSED));
            check("bp_hit",      32'(bp_hit),      32'(m_hit));
            check("seq_err",     32'(seq_err),     32'(m_err));
            check("instr_count", 32'(instr_count), 32'(m_count));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input bit r, input bit s, input bit p);
        run_req = r; step_req = s; pause_req = p;
        tick();
        run_req = 0; step_req = 0; pause_req = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
    endtask

    bit ok;
    int en_cnt;

    initial begin
        do_reset();
        chk_on = 1;
        check("reset_paused", 32'(paused), 32'd1);
        check("reset_cpu_en", 32'(cpu_en), 32'd0);

        // Free run, NEXT at cycle 4, then a pause stops at the next boundary.
        next_at = 4; halt_at = -1;
        pulse(1, 0, 0);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (instr_count == 16'd3) begin ok = 1; break; end
            tick();
        end
        check("run_wait3", 32'(ok), 32'd1);
        check("run_halted", 32'(halted), 32'd0);
        check("run_cycle0", 32'(cycle), 32'd0);
        pulse(0, 0, 1);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (paused) begin ok = 1; break; end
            tick();
        end
        check("pause_wait", 32'(ok), 32'd1);
        check("pause_count", 32'(instr_count), 32'd4);

        // Single step from IDLE with NEXT at the last legal cycle.
        do_reset();
        next_at = 7;
        pulse(0, 1, 0);
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (cpu_en) en_cnt++;
            tick();
        end
        check("step_en_clocks", 32'(en_cnt), 32'd8);
        check("step_paused", 32'(paused), 32'd1);
        check("step_count", 32'(instr_count), 32'd1);
        check("step_cycle", 32'(cycle), 32'd0);

        // Breakpoint at pc=5, then resume with a single step.
        do_reset();
        next_at = 2; bp_en = 1; bp_addr = 4'd5;
        pulse(1, 0, 0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (paused) begin ok = 1; break; end
            tick();
        end
        check("bp_wait", 32'(ok), 32'd1);
        check("bp_hit_set", 32'(bp_hit), 32'd1);
        check("bp_count", 32'(instr_count), 32'd5);
        check("bp_cpu_en", 32'(cpu_en), 32'd0);
        pulse(0, 1, 0);
        check("bp_hit_clr", 32'(bp_hit), 32'd0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (paused) begin ok = 1; break; end
            tick();
        end
        check("bp_step_wait", 32'(ok), 32'd1);
        check("bp_step_count", 32'(instr_count), 32'd6);
        check("bp_step_pc", 32'(pc), 32'd6);
        bp_en = 0;

        // HLT at cycle 2: absorbing until reset, then async reset.
        do_reset();
        next_at = -1; halt_at = 2;
        pulse(1, 0, 0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (halted) begin ok = 1; break; end
            tick();
        end
        check("halt_wait", 32'(ok), 32'd1);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        tick();
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_cycle", 32'(cycle), 32'd2);
        check("halt_cpu_en", 32'(cpu_en), 32'd0);
        reset_n = 0;
        #1;
        check("halt_rst_cycle", 32'(cycle), 32'd0);
        check("halt_rst_idle", 32'(paused), 32'd1);
        tick();
        reset_n = 1;

        // No NEXT ever: overrun wraps and sets the sticky error.
        halt_at = -1; next_at = -1;
        pulse(1, 0, 0);
        for (int i = 0; i < 12; i++) tick();
        check("ovr_err", 32'(seq_err), 32'd1);
        check("ovr_count", 32'(instr_count), 32'd0);
        check("ovr_cycle", 32'(cycle), 32'd4);

        // run+pause together from IDLE, mid-instruction pause, async reset.
        do_reset();
        next_at = 5;
        pulse(1, 0, 1);
        check("prio_run", 32'(paused), 32'd0);
        tick();
        tick();
        pulse(0, 0, 1);
        check("midpause_running", 32'(cpu_en), 32'd1);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (paused) begin ok = 1; break; end
            tick();
        end
        check("midpause_wait", 32'(ok), 32'd1);
        check("midpause_count", 32'(instr_count), 32'd1);
        pulse(1, 0, 0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (cycle == 4'd3) begin ok = 1; break; end
            tick();
        end
        check("rst3_wait", 32'(ok), 32'd1);
        #1;
        reset_n = 0;
        #1;
        check("rst3_cycle", 32'(cycle), 32'd0);
        check("rst3_count", 32'(instr_count), 32'd0);
        tick();
        reset_n = 1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
